// File: rtl/vu_vxu_pkg.sv
// Shared VXU definitions: command/immediate queue widths and the command field layout.
package vu_vxu_pkg;

  localparam int VXU_CMD_W = 20;
  localparam int VXU_IMM_W = 64;

  // Command word layout as decoded by the issue stage; widths sum to VXU_CMD_W.
  localparam int VXU_CMD_OP_W = 8;
  localparam int VXU_CMD_VD_W = 6;
  localparam int VXU_CMD_VS_W = 6;

  typedef struct packed {
    logic [VXU_CMD_OP_W-1:0] op;
    logic [VXU_CMD_VD_W-1:0] vd;
    logic [VXU_CMD_VS_W-1:0] vs;
  } vxu_cmd_t;

endpackage

// File: rtl/vu_queue.sv
// Generic registered FIFO with separate occupancy count and single-cycle flush.
module vu_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             enq_val_i,
  output logic             enq_rdy_o,
  input  logic [WIDTH-1:0] enq_bits_i,
  output logic             deq_val_o,
  input  logic             deq_rdy_i,
  output logic [WIDTH-1:0] deq_bits_o,
  output logic [CNT_W-1:0] count_o
);

  // Handshake: a transfer happens on a rising edge where val & rdy are both 1.
  // rdy and val depend only on the registered count, never on the partner's
  // val/rdy, so a full queue refuses an enqueue even while it is being drained.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enq_fire;
  logic             deq_fire;

  assign enq_rdy_o  = (cnt_q < CNT_W'(DEPTH));
  assign deq_val_o  = (cnt_q != '0);
  assign deq_bits_o = mem_q[rd_ptr_q];
  assign count_o    = cnt_q;

  assign enq_fire = enq_val_i & enq_rdy_o;
  assign deq_fire = deq_rdy_i & deq_val_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (enq_fire && !deq_fire) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (!enq_fire && deq_fire) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is cleared on reset so the head bits are never X while empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (enq_fire && !flush_i) begin
      mem_q[wr_ptr_q] <= enq_bits_i;
    end
  end

endmodule

// File: rtl/vu_vxu_cmdq_buffer.sv
// Command and immediate decoupling queues in front of the VXU issue stage.
module vu_vxu_cmdq_buffer
  import vu_vxu_pkg::*;
#(
  parameter int CMD_W     = VXU_CMD_W,
  parameter int IMM_W     = VXU_IMM_W,
  parameter int CMD_DEPTH = 8,
  parameter int IMM_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [CMD_W-1:0]               enq_cmd_bits,
  input  logic                           enq_cmd_val,
  output logic                           enq_cmd_rdy,
  input  logic [IMM_W-1:0]               enq_imm_bits,
  input  logic                           enq_imm_val,
  output logic                           enq_imm_rdy,
  output logic [CMD_W-1:0]               vxu_cmdq_bits,
  output logic                           vxu_cmdq_val,
  input  logic                           vxu_cmdq_rdy,
  output logic [IMM_W-1:0]               vxu_immq_bits,
  output logic                           vxu_immq_val,
  input  logic                           vxu_immq_rdy,
  output logic [$clog2(CMD_DEPTH+1)-1:0] cmdq_cnt,
  output logic [$clog2(IMM_DEPTH+1)-1:0] immq_cnt,
  output logic                           idle
);

  vu_queue #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmdq (
    .clk_i      (clk),
    .rst_ni     (reset),
    .flush_i    (flush),
    .enq_val_i  (enq_cmd_val),
    .enq_rdy_o  (enq_cmd_rdy),
    .enq_bits_i (enq_cmd_bits),
    .deq_val_o  (vxu_cmdq_val),
    .deq_rdy_i  (vxu_cmdq_rdy),
    .deq_bits_o (vxu_cmdq_bits),
    .count_o    (cmdq_cnt)
  );

  vu_queue #(.WIDTH(IMM_W), .DEPTH(IMM_DEPTH)) u_immq (
    .clk_i      (clk),
    .rst_ni     (reset),
    .flush_i    (flush),
    .enq_val_i  (enq_imm_val),
    .enq_rdy_o  (enq_imm_rdy),
    .enq_bits_i (enq_imm_bits),
    .deq_val_o  (vxu_immq_val),
    .deq_rdy_i  (vxu_immq_rdy),
    .deq_bits_o (vxu_immq_bits),
    .count_o    (immq_cnt)
  );

  // Fences wait on this; built from the registered counts only.
  assign idle = (cmdq_cnt == '0) && (immq_cnt == '0);

endmodule

// File: tb/tb_vu_vxu_cmdq_buffer.sv
// Directed bench for vu_vxu_cmdq_buffer with a queue-based reference model.
module tb_vu_vxu_cmdq_buffer;

  localparam int CMD_W     = 20;
  localparam int IMM_W     = 64;
  localparam int CMD_DEPTH = 8;
  localparam int IMM_DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [CMD_W-1:0] enq_cmd_bits;
  logic             enq_cmd_val;
  logic             enq_cmd_rdy;
  logic [IMM_W-1:0] enq_imm_bits;
  logic             enq_imm_val;
  logic             enq_imm_rdy;
  logic [CMD_W-1:0] vxu_cmdq_bits;
  logic             vxu_cmdq_val;
  logic             vxu_cmdq_rdy;
  logic [IMM_W-1:0] vxu_immq_bits;
  logic             vxu_immq_val;
  logic             vxu_immq_rdy;
  logic [3:0]       cmdq_cnt;
  logic [3:0]       immq_cnt;
  logic             idle;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  logic [CMD_W-1:0] exp_cmd_q[$];
  logic [IMM_W-1:0] exp_imm_q[$];

  // ---------------- clock / DUT ----------------
  always #5 clk = ~clk;

  vu_vxu_cmdq_buffer #(
    .CMD_W(CMD_W), .IMM_W(IMM_W), .CMD_DEPTH(CMD_DEPTH), .IMM_DEPTH(IMM_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .enq_cmd_bits  (enq_cmd_bits),
    .enq_cmd_val   (enq_cmd_val),
    .enq_cmd_rdy   (enq_cmd_rdy),
    .enq_imm_bits  (enq_imm_bits),
    .enq_imm_val   (enq_imm_val),
    .enq_imm_rdy   (enq_imm_rdy),
    .vxu_cmdq_bits (vxu_cmdq_bits),
    .vxu_cmdq_val  (vxu_cmdq_val),
    .vxu_cmdq_rdy  (vxu_cmdq_rdy),
    .vxu_immq_bits (vxu_immq_bits),
    .vxu_immq_val  (vxu_immq_val),
    .vxu_immq_rdy  (vxu_immq_rdy),
    .cmdq_cnt      (cmdq_cnt),
    .immq_cnt      (immq_cnt),
    .idle          (idle)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Two plain FIFOs: accept while fewer than DEPTH words held, pop while non-empty.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_cmd_q.delete();
      exp_imm_q.delete();
    end else if (flush) begin
      exp_cmd_q.delete();
      exp_imm_q.delete();
    end else begin
      bit cmd_deq, cmd_enq, imm_deq, imm_enq;
      cmd_deq = vxu_cmdq_rdy && (exp_cmd_q.size() > 0);
      cmd_enq = enq_cmd_val && (exp_cmd_q.size() < CMD_DEPTH);
      imm_deq = vxu_immq_rdy && (exp_imm_q.size() > 0);
      imm_enq = enq_imm_val && (exp_imm_q.size() < IMM_DEPTH);
      if (cmd_deq) void'(exp_cmd_q.pop_front());
      if (cmd_enq) exp_cmd_q.push_back(enq_cmd_bits);
      if (imm_deq) void'(exp_imm_q.pop_front());
      if (imm_enq) exp_imm_q.push_back(enq_imm_bits);
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmd_val", vxu_cmdq_val, exp_cmd_q.size() != 0);
      if (exp_cmd_q.size() != 0) check("cmd_bits", vxu_cmdq_bits, exp_cmd_q[0]);
      check("cmd_cnt", cmdq_cnt, exp_cmd_q.size());
      check("cmd_rdy", enq_cmd_rdy, exp_cmd_q.size() < CMD_DEPTH);
      check("imm_val", vxu_immq_val, exp_imm_q.size() != 0);
      if (exp_imm_q.size() != 0) check("imm_bits", vxu_immq_bits, exp_imm_q[0]);
      check("imm_cnt", immq_cnt, exp_imm_q.size());
      check("imm_rdy", enq_imm_rdy, exp_imm_q.size() < IMM_DEPTH);
      check("idle", idle, (exp_cmd_q.size() == 0) && (exp_imm_q.size() == 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    flush        = 1'b0;
    enq_cmd_val  = 1'b0;
    enq_cmd_bits = '0;
    enq_imm_val  = 1'b0;
    enq_imm_bits = '0;
    vxu_cmdq_rdy = 1'b0;
    vxu_immq_rdy = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b0;
    idle_inputs();
    cmp_en = 1'b1;
    cycles(2);
    check("rst_cmd_val", vxu_cmdq_val, 1'b0);
    check("rst_cmd_rdy", enq_cmd_rdy, 1'b1);
    check("rst_cmd_cnt", cmdq_cnt, 4'd0);
    check("rst_idle", idle, 1'b1);
    check("rst_cmd_bits", vxu_cmdq_bits, 20'h0);
    check("rst_imm_bits", vxu_immq_bits, 64'h0);
    reset = 1'b1;
    cycles(1);

    // Fill to full; the 9th word must be held off.
    for (int i = 1; i <= 9; i++) begin
      enq_cmd_val  = 1'b1;
      enq_cmd_bits = CMD_W'(i);
      cycles(1);
    end
    check("full_cnt", cmdq_cnt, 4'd8);
    check("full_rdy", enq_cmd_rdy, 1'b0);
    enq_cmd_val  = 1'b0;
    vxu_cmdq_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", vxu_cmdq_bits, 64'(i));
      cycles(1);
    end
    check("drain_empty", vxu_cmdq_val, 1'b0);

    // Enqueue into empty: not visible before the edge, visible after it.
    enq_cmd_val  = 1'b1;
    enq_cmd_bits = 20'h12345;
    check("pt_before", vxu_cmdq_val, 1'b0);
    cycles(1);
    enq_cmd_val = 1'b0;
    check("pt_val", vxu_cmdq_val, 1'b1);
    check("pt_bits", vxu_cmdq_bits, 20'h12345);
    cycles(1);
    check("pt_idle", idle, 1'b1);
    vxu_cmdq_rdy = 1'b0;

    // Steady state at count 3 with one enq and one deq per cycle.
    for (int i = 0; i < 3; i++) begin
      enq_cmd_val  = 1'b1;
      enq_cmd_bits = CMD_W'(20'h100 + i);
      cycles(1);
    end
    vxu_cmdq_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      enq_cmd_bits = CMD_W'(20'h200 + i);
      cycles(1);
      check("steady_cnt", cmdq_cnt, 4'd3);
    end
    check("steady_head", vxu_cmdq_bits, 20'h211);
    enq_cmd_val = 1'b0;
    cycles(3);
    vxu_cmdq_rdy = 1'b0;
    check("steady_drained", cmdq_cnt, 4'd0);

    // Flush with 5 commands and 2 immediates held, plus a concurrent enqueue.
    for (int i = 0; i < 5; i++) begin
      enq_cmd_val  = 1'b1;
      enq_cmd_bits = CMD_W'(20'h300 + i);
      enq_imm_val  = (i < 2);
      enq_imm_bits = 64'h1000 + 64'(i);
      cycles(1);
    end
    check("pre_flush_cmd", cmdq_cnt, 4'd5);
    check("pre_flush_imm", immq_cnt, 4'd2);
    flush        = 1'b1;
    enq_cmd_val  = 1'b1;
    enq_cmd_bits = 20'hABCDE;
    enq_imm_val  = 1'b1;
    enq_imm_bits = 64'hFFFF;
    cycles(1);
    idle_inputs();
    check("flush_cmd_cnt", cmdq_cnt, 4'd0);
    check("flush_imm_cnt", immq_cnt, 4'd0);
    check("flush_idle", idle, 1'b1);
    cycles(1);
    check("flush_discard", vxu_cmdq_val, 1'b0);

    // Immediates flow while the command queue stays empty.
    enq_imm_val  = 1'b1;
    enq_imm_bits = 64'hDEADBEEF_00000001;
    cycles(1);
    enq_imm_bits = 64'h2;
    cycles(1);
    enq_imm_val = 1'b0;
    check("imm_cnt2", immq_cnt, 4'd2);
    check("imm_val_ind", vxu_immq_val, 1'b1);
    check("imm_cmd_val", vxu_cmdq_val, 1'b0);
    vxu_immq_rdy = 1'b1;
    check("imm_pop0", vxu_immq_bits, 64'hDEADBEEF_00000001);
    cycles(1);
    check("imm_pop1", vxu_immq_bits, 64'h2);
    cycles(1);
    check("imm_empty", vxu_immq_val, 1'b0);
    idle_inputs();

    // Asynchronous reset mid-stream discards held words.
    for (int i = 0; i < 3; i++) begin
      enq_cmd_val  = 1'b1;
      enq_cmd_bits = CMD_W'($urandom_range(1, 20'hFFFFF));
      cycles(1);
    end
    enq_cmd_val = 1'b0;
    #2 reset = 1'b0;
    #1 check("async_rst_cnt", cmdq_cnt, 4'd0);
    check("async_rst_bits", vxu_cmdq_bits, 20'h0);
    cycles(1);
    reset = 1'b1;
    cycles(2);
    check("post_rst_idle", idle, 1'b1);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
